hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage RISC-V core (F/D/E/M/W).
//  Generates per-stage stall/bubble from load-use, taken branch, multi-cycle MDU,
//  and instruction/data memory wait handshakes. Supports multi-cycle load latency
//  and keeps a saturating stall-cycle performance counter. Sits beside the pipeline registers.
// PARAMETERS
//  REG_AW    5   register address width
//  LOAD_LAT  1   cycles (>=1) a dependent instruction is held in D after a load leaves E
//  CNT_W     32  width of stall-cycle counter
// PORTS
//  clk_i           in   1       clock, rising edge
//  rst_n_i         in   1       asynchronous reset, active-low
//  E_opcode_i      in   7       opcode of instruction in E
//  E_rd_i          in   REG_AW  destination register in E
//  D_rs1_i/D_rs2_i in   REG_AW  sources of instruction in D
//  D_use_rs1_i/D_use_rs2_i in 1 D instruction really reads rs1/rs2
//  e_Cnd_i         in   1       E resolves a redirect (taken branch/jump)
//  E_mdu_start_i   in   1       E holds a mul/div op, starting this cycle
//  E_mdu_done_i    in   1       MDU result valid this cycle
//  F_imem_ready_i  in   1       instruction fetch completes this cycle
//  M_dmem_req_i    in   1       M holds a load/store
//  M_dmem_ready_i  in   1       data access completes this cycle
//  F/D/E/M/W_stall_o   out 1 each  hold stage register
//  F/D/E/M/W_bubble_o  out 1 each  load NOP into stage register
//  hz_state_o      out  2       FSM state (debug)
//  stall_cnt_o     out  CNT_W   cycles with F_stall_o=1, saturating
// BEHAVIOUR
//  Reset (rst_n_i=0, async): state=RUN, lu_cnt=0, stall_cnt_o=0; all stall/bubble outputs forced 0.
//  Hazard terms (combinational):
//   load_use = E_opcode_i==`OP_LOAD && E_rd_i!=0 &&
//              ((D_use_rs1_i && E_rd_i==D_rs1_i) || (D_use_rs2_i && E_rd_i==D_rs2_i))
//   mem_wait = M_dmem_req_i && !M_dmem_ready_i;  if_wait = !F_imem_ready_i
//  FSM states: RUN, LU (load-use extension), MDU (busy), MEMW (data wait).
//   RUN -> MEMW if mem_wait; else -> MDU if E_mdu_start_i && !E_mdu_done_i;
//          else -> LU if load_use && LOAD_LAT>1 (lu_cnt<=LOAD_LAT-1); else stay.
//   MEMW-> RUN when M_dmem_ready_i.  MDU -> RUN when E_mdu_done_i (and !mem_wait).
//   LU  -> lu_cnt decrements each cycle; -> RUN when lu_cnt==1. mem_wait preempts to MEMW,
//          lu_cnt frozen, resumed (LU) on exit.
//  Priority of actions in one cycle (highest first, lower terms only add, never clear):
//   1 mem_wait/MEMW : stall F,D,E,M; bubble W.
//   2 MDU busy      : stall F,D,E; bubble M. Done cycle: no MDU stall.
//   3 load_use / LU : stall F,D; bubble E.
//   4 e_Cnd_i       : bubble D,E; only when E not stalled (redirect applied on release cycle;
//                     e_Cnd_i held by stalled E, so no latch needed). Overrides stall D from 3.
//   5 if_wait       : stall F; bubble D (unless D stalled by 1-3).
//  Never assert stall and bubble on the same stage; stall wins except rule 4.
//  Latency: outputs combinational from state+inputs same cycle; state updates on clk_i.
//  stall_cnt_o increments when F_stall_o=1, holds at 2^CNT_W-1.
//  x0 destination never creates a hazard. Reset mid-stall returns to RUN, no pending flush.
// STRUCTURE
//  define.v: OP_LOAD, HZ_RUN/HZ_LU/HZ_MDU/HZ_MEMW state encodings.
//  One sub-module: sat_counter (CNT_W) for stall_cnt_o. FSM + lu_cnt in this module.
// TESTING
//  1 lw x5 in E, D reads x5, LOAD_LAT=1 -> one cycle F/D stall + E bubble, state stays RUN.
//  2 same with LOAD_LAT=3 -> F/D stalled 3 cycles, hz_state_o=LU for 2, stall_cnt_o=3.
//  3 lw x0 in E, D reads x0; or D_use_rs2_i=0 with rs2 match -> no stall.
//  4 e_Cnd_i=1 while M_dmem_ready_i low 2 cycles -> MEMW stall F-M, no D/E bubble until
//    ready cycle; then D,E bubble exactly once.
//  5 E_mdu_start_i, done after 4 cycles -> F,D,E stalled, M bubbled 4 cycles, RUN on done.
//  6 rst_n_i low mid-LU -> all outputs 0 immediately, state RUN, counter 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Opcode match value and FSM state type.
package hazard_ctrl_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    HZ_RUN  = 2'd0,
    HZ_LU   = 2'd1,
    HZ_MDU  = 2'd2,
    HZ_MEMW = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for stall-cycle accounting.
// Holds at all-ones instead of wrapping.
module hazard_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      r_cnt <= '0;
    else if (en_i && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: per-stage stall/bubble
// from load-use, redirect, MDU busy and memory wait.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [6:0]        E_opcode_i,
  input  logic [REG_AW-1:0] E_rd_i,
  input  logic [REG_AW-1:0] D_rs1_i,
  input  logic [REG_AW-1:0] D_rs2_i,
  input  logic              D_use_rs1_i,
  input  logic              D_use_rs2_i,
  input  logic              e_Cnd_i,
  input  logic              E_mdu_start_i,
  input  logic              E_mdu_done_i,
  input  logic              F_imem_ready_i,
  input  logic              M_dmem_req_i,
  input  logic              M_dmem_ready_i,
  output logic              F_stall_o,
  output logic              D_stall_o,
  output logic              E_stall_o,
  output logic              M_stall_o,
  output logic              W_stall_o,
  output logic              F_bubble_o,
  output logic              D_bubble_o,
  output logic              E_bubble_o,
  output logic              M_bubble_o,
  output logic              W_bubble_o,
  output logic [1:0]        hz_state_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int LUW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  hz_state_t      r_state, w_nstate;
  logic [LUW-1:0] r_lu, w_nlu;

  logic w_load_use, w_mem_wait, w_if_wait;
  logic w_memw, w_mdu, w_lu, w_ecnd;
  logic w_fs, w_ds, w_es, w_ms;
  logic w_db, w_eb, w_mb, w_wb;

  assign w_load_use = (E_opcode_i == OP_LOAD) && (E_rd_i != '0) &&
                      ((D_use_rs1_i && (E_rd_i == D_rs1_i)) ||
                       (D_use_rs2_i && (E_rd_i == D_rs2_i)));
  assign w_mem_wait = M_dmem_req_i && !M_dmem_ready_i;
  assign w_if_wait  = !F_imem_ready_i;

  assign w_memw = w_mem_wait ||
                  ((r_state == HZ_MEMW) && !M_dmem_ready_i);
  assign w_mdu  = ((r_state == HZ_MDU) || E_mdu_start_i) &&
                  !E_mdu_done_i;
  assign w_lu   = w_load_use || (r_state == HZ_LU);
  // Redirect waits until E is released; e_Cnd_i stays held meanwhile.
  assign w_ecnd = e_Cnd_i && !w_memw && !w_mdu;

  assign w_es = w_memw || w_mdu;
  assign w_ms = w_memw;
  assign w_ds = w_es || (w_lu && !w_ecnd);
  assign w_fs = w_es || w_lu || w_if_wait;

  assign w_wb = w_memw;
  assign w_mb = w_mdu && !w_memw;
  assign w_eb = (w_lu && !w_es) || w_ecnd;
  assign w_db = w_ecnd || (w_if_wait && !w_ds);

  always_comb begin
    w_nstate = r_state;
    w_nlu    = r_lu;
    unique case (r_state)
      HZ_RUN: begin
        if (w_mem_wait)
          w_nstate = HZ_MEMW;
        else if (E_mdu_start_i && !E_mdu_done_i)
          w_nstate = HZ_MDU;
        else if (w_load_use && (LOAD_LAT > 1)) begin
          w_nstate = HZ_LU;
          w_nlu    = LUW'(LOAD_LAT - 1);
        end
      end
      HZ_LU: begin
        // Memory wait freezes the remaining load-use count.
        if (w_mem_wait)
          w_nstate = HZ_MEMW;
        else begin
          w_nlu = r_lu - 1'b1;
          if (r_lu == LUW'(1))
            w_nstate = HZ_RUN;
        end
      end
      HZ_MDU: begin
        if (E_mdu_done_i)
          w_nstate = w_mem_wait ? HZ_MEMW : HZ_RUN;
      end
      HZ_MEMW: begin
        if (M_dmem_ready_i)
          w_nstate = (r_lu != '0) ? HZ_LU : HZ_RUN;
      end
      default: w_nstate = HZ_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= HZ_RUN;
      r_lu    <= '0;
    end else begin
      r_state <= w_nstate;
      r_lu    <= w_nlu;
    end
  end

  assign F_stall_o  = rst_n_i && w_fs;
  assign D_stall_o  = rst_n_i && w_ds;
  assign E_stall_o  = rst_n_i && w_es;
  assign M_stall_o  = rst_n_i && w_ms;
  assign W_stall_o  = 1'b0;
  assign F_bubble_o = 1'b0;
  assign D_bubble_o = rst_n_i && w_db;
  assign E_bubble_o = rst_n_i && w_eb;
  assign M_bubble_o = rst_n_i && w_mb;
  assign W_bubble_o = rst_n_i && w_wb;
  assign hz_state_o = r_state;

  hazard_ctrl_sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (F_stall_o),
    .cnt_o   (stall_cnt_o)
  );

endmodule
